mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency unified memory between two requesters: the instruction fetch port (IF) and the data memory port (MEM stage).
- Sequences every access as issue, wait, respond.
- Generates per-port stall signals for the pipeline hazard logic.
- Produces byte enables and lane alignment for the word/half/byte load and store codes.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and data ports.
// Latency: read valid at C+2+MEM_LATENCY, write at C+2, misaligned data at C+1 (C = arbitration cycle).
// Backpressure: one access in flight; the losing or waiting requester sees its stall until its valid pulse.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_err,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt;
  logic [2:0]  cnt;
  logic        win_dm;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_err;

  logic        grant_dm;
  logic        any_req;
  logic [1:0]  req_size;
  logic [3:0]  dm_be;
  logic [31:0] dm_wd;
  logic        dm_mis;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic        unused_if_lsb;

  // Fetch addresses are always word aligned; the low bits carry no information.
  assign unused_if_lsb = &{1'b0, if_addr[1:0]};

  // Data wins unless IF has been passed over STARVE_LIMIT times in a row.
  assign any_req  = if_req || dm_req;
  assign grant_dm = dm_req && !(if_req && (starve_cnt == 4'(STARVE_LIMIT)));

  // Decode size/offset of the data request into lane enables, replicated store data and a misalignment flag.
  always_comb begin
    req_size = (dm_size == 2'b11) ? 2'b00 : dm_size;
    dm_be    = 4'b1111;
    dm_wd    = dm_wdata;
    dm_mis   = 1'b0;
    case (req_size)
      2'b01: begin
        dm_be  = dm_addr[1] ? 4'b1100 : 4'b0011;
        dm_wd  = {2{dm_wdata[15:0]}};
        dm_mis = dm_addr[0];
      end
      2'b10: begin
        dm_be  = 4'b0001 << dm_addr[1:0];
        dm_wd  = {4{dm_wdata[7:0]}};
      end
      default: begin
        dm_mis = |dm_addr[1:0];
      end
    endcase
  end

  // Shift the selected lane of the returning word down to bit 0 and zero-fill the rest.
  assign ld_byte = 8'(mem_rdata >> {lat_off, 3'b000});
  always_comb begin
    ld_data = mem_rdata;
    case (lat_size)
      2'b01:   ld_data = lat_off[1] ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]};
      2'b10:   ld_data = {24'h0, ld_byte};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state: issue, wait out the memory latency, then one DONE cycle that never re-arbitrates.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (any_req) state_nxt = (grant_dm && dm_mis) ? DONE : ISSUE;
      ISSUE: state_nxt = lat_we ? DONE : WAIT;
      WAIT:  if (cnt == 3'd0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the per-access latches, starvation counter and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      cnt        <= 3'd0;
      win_dm     <= 1'b0;
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_off    <= 2'b00;
      lat_err    <= 1'b0;
      mem_be     <= 4'b0000;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      if_rdata   <= 32'h0;
      dm_rdata   <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_dm && if_req) begin
            if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= 4'd0;
          end
          if (any_req) begin
            win_dm <= grant_dm;
            if (grant_dm) begin
              mem_addr  <= {dm_addr[31:2], 2'b00};
              mem_be    <= dm_be;
              mem_wdata <= dm_wd;
              lat_we    <= dm_we;
              lat_size  <= req_size;
              lat_off   <= dm_addr[1:0];
              lat_err   <= dm_mis;
            end else begin
              mem_addr  <= {if_addr[31:2], 2'b00};
              mem_be    <= 4'b1111;
              mem_wdata <= 32'h0;
              lat_we    <= 1'b0;
              lat_size  <= 2'b00;
              lat_off   <= 2'b00;
              lat_err   <= 1'b0;
            end
          end
        end
        ISSUE: cnt <= 3'(MEM_LATENCY - 1);
        WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else if (win_dm) begin
            dm_rdata <= ld_data;
          end else begin
            if_rdata <= ld_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en   = (state == ISSUE);
  assign mem_we   = mem_en && lat_we;
  assign if_valid = (state == DONE) && !win_dm;
  assign dm_valid = (state == DONE) && win_dm;
  assign dm_err   = dm_valid && lat_err;
  assign busy     = (state != IDLE);
  assign if_stall = if_req && !if_valid;
  assign dm_stall = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-level golden memory plus transaction-level arbitration model.
// Directed steps from the test plan followed by randomized single/dual-port traffic.
// The memory model returns data only in the exact cycle it is due; other cycles carry noise.
module tb_mem_port_arbiter;
  localparam int L  = 2;
  localparam int SL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        dm_req, dm_we;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_valid, dm_err, dm_stall;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_err(dm_err), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int nchk  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Word-wide memory seen by the DUT, and byte-wide golden copy kept by the model.
  logic [31:0] wmem [256];
  logic [7:0]  gmem [1024];
  int          cyc = 0;
  int          due = -1;
  logic [7:0]  pidx = 8'h0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int j = 0; j < 4; j++)
          if (mem_be[j]) wmem[mem_addr[9:2]][8*j +: 8] = mem_wdata[8*j +: 8];
      end else begin
        pidx = mem_addr[9:2];
        due  = cyc + L;
      end
    end
    cyc++;
    mem_rdata <= (cyc == due) ? wmem[pidx] : $urandom;
  end

  int          m_starve = 0;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    wmem[w] = v;
    for (int j = 0; j < 4; j++) gmem[4*w + j] = v[8*j +: 8];
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_if_rdata"}, if_rdata, 32'h0);
    chk1({pfx, "_if_valid"}, if_valid, 1'b0);
    chk1({pfx, "_if_stall"}, if_stall, 1'b0);
    chk({pfx, "_dm_rdata"}, dm_rdata, 32'h0);
    chk1({pfx, "_dm_valid"}, dm_valid, 1'b0);
    chk1({pfx, "_dm_err"}, dm_err, 1'b0);
    chk1({pfx, "_dm_stall"}, dm_stall, 1'b0);
    chk1({pfx, "_mem_en"}, mem_en, 1'b0);
    chk1({pfx, "_mem_we"}, mem_we, 1'b0);
    chk({pfx, "_mem_be"}, {28'h0, mem_be}, 32'h0);
    chk({pfx, "_mem_addr"}, mem_addr, 32'h0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 32'h0);
    chk1({pfx, "_busy"}, busy, 1'b0);
  endtask

  // Serve one access starting from an IDLE cycle whose inputs are already driven.
  // Ends in the following IDLE cycle with the winner's request dropped.
  task automatic one_txn(input int drop_at, input int raise_dm_at, output bit won_dm);
    bit          g, mis, we, vi, vd;
    int          n, d, lane, bidx;
    logic [31:0] a, exp_ld, exp_wd;
    logic [3:0]  exp_be;
    #1;
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_mem_en", mem_en, 1'b0);
    chk1("idle_if_stall", if_stall, if_req);
    chk1("idle_dm_stall", dm_stall, dm_req);
    g = dm_req && !(if_req && m_starve == SL);
    if (g && if_req) begin
      if (m_starve < SL) m_starve++;
    end else begin
      m_starve = 0;
    end
    if (g) begin
      a  = dm_addr;
      we = dm_we;
      n  = (dm_size == 2'b01) ? 2 : (dm_size == 2'b10) ? 1 : 4;
      mis = (int'(a[1:0]) % n) != 0;
    end else begin
      a  = {if_addr[31:2], 2'b00};
      we = 1'b0;
      n  = 4;
      mis = 1'b0;
    end
    exp_be = 4'h0;
    exp_ld = 32'h0;
    exp_wd = 32'h0;
    for (int i = 0; i < n; i++) begin
      lane = (int'(a[1:0]) + i) % 4;
      bidx = (int'(a[9:0]) + i) % 1024;
      exp_be[lane] = 1'b1;
      exp_ld = exp_ld | (32'(gmem[bidx]) << (8*i));
    end
    for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = 8'(dm_wdata >> (8*(j % n)));
    d = mis ? 1 : (we ? 2 : 2 + L);
    for (int k = 1; k <= d; k++) begin
      step();
      vi = (k == d) && !g;
      vd = (k == d) && g;
      chk1("if_valid", if_valid, vi);
      chk1("dm_valid", dm_valid, vd);
      chk1("dm_err", dm_err, vd && mis);
      chk1("mem_en", mem_en, k == 1 && !mis);
      chk1("mem_we", mem_we, k == 1 && !mis && we);
      chk1("busy", busy, 1'b1);
      chk1("if_stall", if_stall, if_req && !vi);
      chk1("dm_stall", dm_stall, dm_req && !vd);
      if (k == 1 && !mis) begin
        obs_be = mem_be; obs_wdata = mem_wdata; obs_addr = mem_addr;
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
        if (we) chk("mem_wdata", mem_wdata, exp_wd);
      end
      if (k == d && !we && !mis) begin
        if (g) chk("dm_rdata", dm_rdata, exp_ld);
        else   chk("if_rdata", if_rdata, exp_ld);
      end
      if (k == d && g && we && !mis)
        for (int i = 0; i < n; i++) gmem[(int'(a[9:0]) + i) % 1024] = 8'(dm_wdata >> (8*i));
      if (k == drop_at && !g) if_req = 1'b0;
      if (k == raise_dm_at) dm_req = 1'b1;
      if (k == d) begin
        if (g) dm_req = 1'b0;
        else   if_req = 1'b0;
      end
    end
    step();
    chk1("after_busy", busy, 1'b0);
    chk1("after_if_valid", if_valid, 1'b0);
    chk1("after_dm_valid", dm_valid, 1'b0);
    won_dm = g;
  endtask

  initial begin
    bit w;
    bit exp_order [6];
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = 32'h0; dm_wdata = 32'h0;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    set_word(32'h40 >> 2, 32'hDEAD_BEEF);
    set_word(32'h204 >> 2, 32'h1234_5678);
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    // Lone fetch from an unaligned address.
    if_addr = 32'h0000_0043; if_req = 1'b1;
    one_txn(0, 0, w);
    chk1("fetch_grant", w, 1'b0);
    chk("fetch_addr", obs_addr, 32'h40);
    chk("fetch_be", {28'h0, obs_be}, 32'hF);
    chk("fetch_data", if_rdata, 32'hDEAD_BEEF);

    // Byte store.
    dm_addr = 32'h102; dm_wdata = 32'h0000_00A5; dm_we = 1'b1; dm_size = 2'b10; dm_req = 1'b1;
    one_txn(0, 0, w);
    chk("bst_be", {28'h0, obs_be}, 32'h4);
    chk("bst_wdata", obs_wdata, 32'hA5A5_A5A5);

    // Half load from the upper half.
    dm_addr = 32'h206; dm_we = 1'b0; dm_size = 2'b01; dm_req = 1'b1;
    one_txn(0, 0, w);
    chk("hld_data", dm_rdata, 32'h0000_1234);

    // Misaligned word load.
    dm_addr = 32'h301; dm_size = 2'b00; dm_req = 1'b1;
    one_txn(0, 0, w);

    // Both ports held continuously: D, D, I, D, D, I.
    if_addr = 32'h80; if_req = 1'b1;
    dm_addr = 32'h100; dm_size = 2'b00; dm_we = 1'b0; dm_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      one_txn(0, 0, w);
      chk1("grant_order", w, exp_order[i]);
      if (w) begin dm_req = 1'b1; dm_addr = dm_addr + 32'h4; end
      else   begin if_req = 1'b1; if_addr = if_addr + 32'h4; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    step(); m_starve = 0;

    // IF drops its request during WAIT while a data request arrives.
    if_addr = 32'h44; if_req = 1'b1;
    dm_addr = 32'h204; dm_size = 2'b00; dm_we = 1'b0; dm_req = 1'b0;
    one_txn(2, 1, w);
    chk1("drop_if_grant", w, 1'b0);
    one_txn(0, 0, w);
    chk1("drop_then_dm", w, 1'b1);

    // Reset during WAIT abandons the fetch.
    if_addr = 32'h48; if_req = 1'b1;
    step(); step();
    chk1("rst_wait_busy", busy, 1'b1);
    rst = 1'b1; if_req = 1'b0;
    step();
    check_zero("rst_wait");
    rst = 1'b0; m_starve = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("post_rst_if_valid", if_valid, 1'b0);
      chk1("post_rst_dm_valid", dm_valid, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
    end
    dm_addr = 32'h40; dm_size = 2'b00; dm_we = 1'b0; dm_req = 1'b1;
    one_txn(0, 0, w);
    chk("post_rst_load", dm_rdata, 32'hDEAD_BEEF);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      int mode;
      mode     = $urandom_range(0, 2);
      if_addr  = 32'($urandom_range(0, 1023));
      dm_addr  = 32'($urandom_range(0, 1023));
      dm_size  = 2'($urandom_range(0, 3));
      dm_we    = 1'($urandom_range(0, 1));
      dm_wdata = $urandom;
      if_req   = (mode != 1);
      dm_req   = (mode != 0);
      while (if_req || dm_req) one_txn(0, 0, w);
      if ($urandom_range(0, 3) == 0) begin step(); m_starve = 0; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
